// File: rtl/load_store_buffer_if.sv
// Bus bundle between dispatch/CDB/ROB/memory and the load/store buffer.
// The buffer uses the slave modport; the environment driving it uses master.
interface load_store_buffer_if #(
  parameter int DEPTH = 4
) ();
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             alloc_valid;
  logic             alloc_is_store;
  logic [4:0]       alloc_ROBEN;
  logic [4:0]       alloc_base_Q;
  logic [31:0]      alloc_base_V;
  logic [4:0]       alloc_data_Q;
  logic [31:0]      alloc_data_V;
  logic [31:0]      alloc_imm;
  logic             CDB_valid;
  logic [4:0]       CDB_ROBEN;
  logic [31:0]      CDB_Result;
  logic             commit_valid;
  logic [4:0]       commit_ROBEN;
  logic             flush;
  logic             full;
  logic [CNT_W-1:0] count;
  logic [4:0]       ROBEN;
  logic             Read_en;
  logic             Write_en;
  logic [31:0]      address;
  logic [31:0]      data;

  modport slave (
    input  alloc_valid, alloc_is_store, alloc_ROBEN, alloc_base_Q, alloc_base_V,
           alloc_data_Q, alloc_data_V, alloc_imm, CDB_valid, CDB_ROBEN, CDB_Result,
           commit_valid, commit_ROBEN, flush,
    output full, count, ROBEN, Read_en, Write_en, address, data
  );

  modport master (
    output alloc_valid, alloc_is_store, alloc_ROBEN, alloc_base_Q, alloc_base_V,
           alloc_data_Q, alloc_data_V, alloc_imm, CDB_valid, CDB_ROBEN, CDB_Result,
           commit_valid, commit_ROBEN, flush,
    input  full, count, ROBEN, Read_en, Write_en, address, data
  );
endinterface

// File: rtl/load_store_buffer.sv
// In-order load/store buffer: captures operands from the CDB, waits for store
// commit, and issues one memory access per cycle from the head entry.
module load_store_buffer #(
  parameter int DEPTH = 4
) (
  input logic                clk,
  input logic                rst,
  load_store_buffer_if.slave bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 5;

  logic [DEPTH-1:0]              busy;
  logic [DEPTH-1:0]              is_st;
  logic [DEPTH-1:0]              cmt;
  logic [TAG_W-1:0]              rob_q  [DEPTH];
  logic [TAG_W-1:0]              base_q [DEPTH];
  logic [TAG_W-1:0]              data_q [DEPTH];
  logic [DATA_W-1:0]             base_v [DEPTH];
  logic [DATA_W-1:0]             data_v [DEPTH];
  logic signed [DATA_W-1:0]      imm_q  [DEPTH];

  logic [PTR_W-1:0]              head;
  logic [PTR_W-1:0]              tail;
  logic [CNT_W-1:0]              cnt;

  logic                          rd_en_p0;
  logic                          wr_en_p0;
  logic [TAG_W-1:0]              rob_p0;
  logic [DATA_W-1:0]             addr_p0;
  logic [DATA_W-1:0]             data_p0;

  logic                          full_c;
  logic                          alloc_take;
  logic                          head_rdy;
  logic                          issue_take;

  // Effective address wraps modulo 2^32; range checking is left to memory.
  function automatic logic [DATA_W-1:0] eff_addr(input logic [DATA_W-1:0]        base,
                                                 input logic signed [DATA_W-1:0] off);
    return base + $unsigned(off);
  endfunction

  function automatic logic cdb_hit(input logic             vld,
                                   input logic [TAG_W-1:0] cdb_tag,
                                   input logic [TAG_W-1:0] tag);
    return vld && (tag != '0) && (tag == cdb_tag);
  endfunction

  assign full_c     = (cnt == CNT_W'(DEPTH));
  assign alloc_take = bus.alloc_valid && !full_c && !bus.flush;
  assign head_rdy   = busy[head] && (base_q[head] == '0) &&
                      (!is_st[head] || ((data_q[head] == '0) && cmt[head]));
  assign issue_take = head_rdy && !bus.flush;

  // Issue stage: control state and registered memory-bus outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= '0;
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
      rd_en_p0 <= 1'b0;
      wr_en_p0 <= 1'b0;
      rob_p0   <= '0;
      addr_p0  <= '0;
      data_p0  <= '0;
    end else if (bus.flush) begin
      busy     <= '0;
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
      rd_en_p0 <= 1'b0;
      wr_en_p0 <= 1'b0;
      rob_p0   <= '0;
    end else begin
      rd_en_p0 <= issue_take && !is_st[head];
      wr_en_p0 <= issue_take && is_st[head];
      rob_p0   <= issue_take ? rob_q[head] : '0;
      if (issue_take) begin
        addr_p0    <= eff_addr(base_v[head], imm_q[head]);
        data_p0    <= is_st[head] ? data_v[head] : '0;
        busy[head] <= 1'b0;
        head       <= head + 1'b1;
      end
      if (alloc_take) begin
        busy[tail] <= 1'b1;
        tail       <= tail + 1'b1;
      end
      cnt <= cnt + CNT_W'(alloc_take) - CNT_W'(issue_take);
    end
  end

  // Entry payload: written on allocation, updated by CDB capture and commit
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_take && (tail == PTR_W'(i))) begin
        is_st[i] <= bus.alloc_is_store;
        rob_q[i] <= bus.alloc_ROBEN;
        imm_q[i] <= $signed(bus.alloc_imm);
        cmt[i]   <= 1'b0;
        if (cdb_hit(bus.CDB_valid, bus.CDB_ROBEN, bus.alloc_base_Q)) begin
          base_q[i] <= '0;
          base_v[i] <= bus.CDB_Result;
        end else begin
          base_q[i] <= bus.alloc_base_Q;
          base_v[i] <= bus.alloc_base_V;
        end
        if (cdb_hit(bus.CDB_valid, bus.CDB_ROBEN, bus.alloc_data_Q)) begin
          data_q[i] <= '0;
          data_v[i] <= bus.CDB_Result;
        end else begin
          data_q[i] <= bus.alloc_data_Q;
          data_v[i] <= bus.alloc_data_V;
        end
      end else begin
        if (cdb_hit(bus.CDB_valid, bus.CDB_ROBEN, base_q[i])) begin
          base_q[i] <= '0;
          base_v[i] <= bus.CDB_Result;
        end
        if (cdb_hit(bus.CDB_valid, bus.CDB_ROBEN, data_q[i])) begin
          data_q[i] <= '0;
          data_v[i] <= bus.CDB_Result;
        end
        if (busy[i] && is_st[i] && bus.commit_valid && (rob_q[i] == bus.commit_ROBEN))
          cmt[i] <= 1'b1;
      end
    end
  end

  assign bus.full     = full_c;
  assign bus.count    = cnt;
  assign bus.ROBEN    = rob_p0;
  assign bus.Read_en  = rd_en_p0;
  assign bus.Write_en = wr_en_p0;
  assign bus.address  = addr_p0;
  assign bus.data     = data_p0;
endmodule

// File: tb/tb_load_store_buffer.sv
// Bench for load_store_buffer: directed scenarios plus randomized traffic,
// all checked against a queue-based reference of the buffer's behaviour.
module tb_load_store_buffer;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  load_store_buffer_if #(.DEPTH(DEPTH)) bus ();

  load_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          st;
    logic [4:0]  rob;
    logic [4:0]  bq;
    logic [31:0] bv;
    logic [4:0]  dq;
    logic [31:0] dv;
    logic [31:0] imm;
    bit          cm;
  } ent_t;

  ent_t        q[$];
  logic        e_rd, e_wr;
  logic [4:0]  e_rob;
  logic [31:0] e_addr, e_data;
  int          n_chk = 0;
  int          n_err = 0;
  logic [4:0]  next_rob = 5'd1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit rdy(input ent_t e);
    return (e.bq == 0) && (!e.st || ((e.dq == 0) && e.cm));
  endfunction

  task automatic clr();
    bus.alloc_valid = 0; bus.alloc_is_store = 0; bus.alloc_ROBEN = 0;
    bus.alloc_base_Q = 0; bus.alloc_base_V = 0; bus.alloc_data_Q = 0;
    bus.alloc_data_V = 0; bus.alloc_imm = 0; bus.CDB_valid = 0;
    bus.CDB_ROBEN = 0; bus.CDB_Result = 0; bus.commit_valid = 0;
    bus.commit_ROBEN = 0; bus.flush = 0;
  endtask

  task automatic alloc(input bit st, input logic [4:0] rob, input logic [4:0] bq,
                       input logic [31:0] bv, input logic [4:0] dq,
                       input logic [31:0] dv, input logic [31:0] imm);
    bus.alloc_valid = 1; bus.alloc_is_store = st; bus.alloc_ROBEN = rob;
    bus.alloc_base_Q = bq; bus.alloc_base_V = bv; bus.alloc_data_Q = dq;
    bus.alloc_data_V = dv; bus.alloc_imm = imm;
  endtask

  task automatic model_reset();
    q.delete();
    e_rd = 0; e_wr = 0; e_rob = 0; e_addr = 0; e_data = 0;
  endtask

  // Advance one clock with the inputs currently on the bus, then compare.
  task automatic step();
    ent_t e;
    int   n;
    n = q.size();
    e_rd = 0; e_wr = 0; e_rob = 0;
    if (bus.flush) begin
      q.delete();
    end else begin
      if (n > 0 && rdy(q[0])) begin
        e_rob  = q[0].rob;
        e_addr = q[0].bv + q[0].imm;
        e_data = q[0].st ? q[0].dv : 32'd0;
        e_wr   = q[0].st;
        e_rd   = !q[0].st;
        void'(q.pop_front());
      end
      foreach (q[k]) begin
        if (bus.CDB_valid && q[k].bq != 0 && q[k].bq == bus.CDB_ROBEN) begin
          q[k].bq = 0; q[k].bv = bus.CDB_Result;
        end
        if (bus.CDB_valid && q[k].dq != 0 && q[k].dq == bus.CDB_ROBEN) begin
          q[k].dq = 0; q[k].dv = bus.CDB_Result;
        end
        if (bus.commit_valid && q[k].st && q[k].rob == bus.commit_ROBEN) q[k].cm = 1;
      end
      if (bus.alloc_valid && n < DEPTH) begin
        e.st = bus.alloc_is_store; e.rob = bus.alloc_ROBEN; e.imm = bus.alloc_imm;
        e.bq = bus.alloc_base_Q;   e.bv = bus.alloc_base_V;
        e.dq = bus.alloc_data_Q;   e.dv = bus.alloc_data_V;
        e.cm = 0;
        if (bus.CDB_valid && e.bq != 0 && e.bq == bus.CDB_ROBEN) begin
          e.bq = 0; e.bv = bus.CDB_Result;
        end
        if (bus.CDB_valid && e.dq != 0 && e.dq == bus.CDB_ROBEN) begin
          e.dq = 0; e.dv = bus.CDB_Result;
        end
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    chk("Read_en",  32'(bus.Read_en),  32'(e_rd));
    chk("Write_en", 32'(bus.Write_en), 32'(e_wr));
    chk("ROBEN",    32'(bus.ROBEN),    32'(e_rob));
    chk("address",  bus.address,       e_addr);
    chk("data",     bus.data,          e_data);
    chk("count",    32'(bus.count),    q.size());
    chk("full",     32'(bus.full),     32'(q.size() == DEPTH));
    clr();
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_ROBEN"},    32'(bus.ROBEN),    0);
    chk({tag, "_Read_en"},  32'(bus.Read_en),  0);
    chk({tag, "_Write_en"}, 32'(bus.Write_en), 0);
    chk({tag, "_address"},  bus.address,       0);
    chk({tag, "_data"},     bus.data,          0);
    chk({tag, "_count"},    32'(bus.count),    0);
    chk({tag, "_full"},     32'(bus.full),     0);
  endtask

  initial begin
    rst = 1'b0;
    clr();
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // Load issues one edge after allocation
    alloc(0, 5'd3, 5'd0, 32'd100, 5'd0, 32'd0, 32'd4);
    step();
    chk("ld_not_yet", 32'(bus.Read_en), 0);
    step();
    chk("ld_rd",   32'(bus.Read_en), 1);
    chk("ld_addr", bus.address, 32'd104);
    chk("ld_rob",  32'(bus.ROBEN), 3);
    step();
    chk("ld_after", 32'(bus.Read_en), 0);

    // Store waits for CDB operand and commit
    alloc(1, 5'd5, 5'd7, 32'd0, 5'd0, 32'h000000AB, 32'd8);
    step();
    bus.CDB_valid = 1; bus.CDB_ROBEN = 5'd7; bus.CDB_Result = 32'd200;
    step();
    for (int i = 0; i < 2; i++) begin
      step();
      chk("st_wait", 32'(bus.Write_en), 0);
    end
    bus.commit_valid = 1; bus.commit_ROBEN = 5'd5;
    step();
    chk("st_wait_commit", 32'(bus.Write_en), 0);
    step();
    chk("st_wr",   32'(bus.Write_en), 1);
    chk("st_addr", bus.address, 32'd208);
    chk("st_data", bus.data, 32'h000000AB);

    // Asynchronous reset while Write_en is high
    rst = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    model_reset();
    #1;
    rst = 1'b1;

    // Unready head blocks three ready loads; fifth alloc is dropped
    alloc(0, 5'd10, 5'd12, 32'd0, 5'd0, 32'd0, 32'd16);  step();
    alloc(0, 5'd11, 5'd0, 32'h100, 5'd0, 32'd0, 32'd1);  step();
    alloc(0, 5'd12, 5'd0, 32'h200, 5'd0, 32'd0, 32'd2);  step();
    alloc(0, 5'd13, 5'd0, 32'h300, 5'd0, 32'd0, 32'd3);  step();
    chk("full_set", 32'(bus.full), 1);
    alloc(0, 5'd14, 5'd0, 32'h400, 5'd0, 32'd0, 32'd4);  step();
    chk("full_drop_cnt", 32'(bus.count), 4);
    bus.CDB_valid = 1; bus.CDB_ROBEN = 5'd12; bus.CDB_Result = 32'h1000;
    step();
    chk("blocked", 32'(bus.Read_en), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("order_rd",  32'(bus.Read_en), 1);
      chk("order_rob", 32'(bus.ROBEN), 32'(10 + i));
    end
    step();
    chk("order_done", 32'(bus.count), 0);

    // Same-cycle CDB bypass over enough allocations to wrap the pointers
    for (int i = 0; i < 10; i++) begin
      alloc(0, 5'(i + 1), 5'd9, 32'd0, 5'd0, 32'd0, 32'(i * 4));
      bus.CDB_valid = 1; bus.CDB_ROBEN = 5'd9; bus.CDB_Result = 32'h40;
      step();
      if (i > 0) chk("byp_addr", bus.address, 32'h40 + 32'((i - 1) * 4));
    end
    step();
    chk("byp_last", bus.address, 32'h40 + 32'd36);

    // Flush with a ready head and a concurrent allocation
    alloc(1, 5'd20, 5'd0, 32'h300, 5'd0, 32'h55, 32'd0);  step();
    alloc(0, 5'd21, 5'd5, 32'd0, 5'd0, 32'd0, 32'd0);     step();
    alloc(0, 5'd22, 5'd0, 32'h500, 5'd0, 32'd0, 32'd0);   step();
    bus.commit_valid = 1; bus.commit_ROBEN = 5'd20;
    step();
    chk("pre_flush_cnt", 32'(bus.count), 3);
    bus.flush = 1;
    alloc(0, 5'd23, 5'd0, 32'h600, 5'd0, 32'd0, 32'd0);
    step();
    chk("flush_wr",  32'(bus.Write_en), 0);
    chk("flush_cnt", 32'(bus.count), 0);
    bus.commit_valid = 1; bus.commit_ROBEN = 5'd20;
    step();
    step();
    chk("flush_no_wr", 32'(bus.Write_en), 0);

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 2) != 0) begin
        alloc($urandom_range(0, 1), next_rob,
              ($urandom_range(0, 1) == 1) ? 5'd0 : 5'($urandom_range(1, 3)), $urandom,
              ($urandom_range(0, 1) == 1) ? 5'd0 : 5'($urandom_range(1, 3)), $urandom,
              $urandom);
        next_rob = (next_rob == 5'd31) ? 5'd1 : next_rob + 5'd1;
      end
      if ($urandom_range(0, 1) == 1) begin
        bus.CDB_valid = 1;
        bus.CDB_ROBEN = 5'($urandom_range(1, 3));
        bus.CDB_Result = $urandom;
      end
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        bus.commit_valid = 1;
        bus.commit_ROBEN = q[$urandom_range(0, q.size() - 1)].rob;
      end
      if ($urandom_range(0, 39) == 0) bus.flush = 1;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/load_store_buffer.md
# load_store_buffer

In-order load/store buffer that sits directly upstream of the data-memory stage in the SSOOO core. It accepts memory instructions from dispatch, captures pending operands from the CDB and computes effective addresses. It then issues one access per cycle to the data memory on the `ROBEN`/`Read_en`/`Write_en`/`address`/`data` bus. Loads issue when their operands are ready; stores issue only once the ROB commits them.

## Interface
- `DEPTH`, 4: number of entries (power of two, at least 2).
- `clk`  in  1  core clock. Outputs are registered on posedge; the data memory samples them on the following negedge.
- `rst`  in  1  reset, asynchronous, active-low.
- `alloc_valid`  in  1  dispatch writes a new entry this cycle.
- `alloc_is_store`  in  1  1 = store, 0 = load.
- `alloc_ROBEN`  in  5  ROB tag of the instruction (1..31).
- `alloc_base_Q`  in  5  producer tag of the base register; 0 means the value is ready.
- `alloc_base_V`  in  32  base value, meaningful when `alloc_base_Q`=0.
- `alloc_data_Q`, `alloc_data_V`  in  5, 32  store data tag and value, same rule as the base pair; ignored for loads.
- `alloc_imm`  in  32  sign-extended offset.
- `CDB_valid`, `CDB_ROBEN`, `CDB_Result`  in  1, 5, 32  common data bus broadcast.
- `commit_valid`, `commit_ROBEN`  in  1, 5  ROB retiring the store with this tag.
- `flush`  in  1  mispredict flush; discards all entries.
- `full`  out  1  combinational: count == DEPTH.
- `count`  out  clog2(DEPTH)+1  number of occupied entries.
- `ROBEN`  out  5  tag of the issued access.
- `Read_en`  out  1  load issue pulse.
- `Write_en`  out  1  store issue pulse.
- `address`  out  32  effective address.
- `data`  out  32  store data; 0 for loads.

## Operation
- **Storage.** Circular buffer with head and tail pointers of clog2(DEPTH) bits and wrap-around at DEPTH. Each entry holds: busy, is_store, ROBEN, base_Q/V, data_Q/V, imm, committed.
- **Allocation.** Taken when `alloc_valid` && !`full` && !`flush`; writes at tail and increments tail. `alloc_valid` while `full` is dropped; dispatch must not do this. `full` is not relieved by a same-cycle pop.
- **CDB capture.** Every busy entry with base_Q == `CDB_ROBEN` (nonzero) and `CDB_valid` sets base_V = `CDB_Result` and base_Q = 0. data_Q/data_V follow the same rule.
- **CDB bypass.** An allocating entry whose alloc Q matches the same-cycle CDB captures the value directly and is stored with Q = 0.
- **Commit.** `commit_valid` sets committed on the busy store entry whose ROBEN matches. The bit is sticky until the entry pops. A commit with no matching entry is ignored.
- **Ready rule for the head entry.**
  - Load: base_Q == 0.
  - Store: base_Q == 0 && data_Q == 0 && committed.
- **Issue.** Only the head entry can issue; there is no reordering, so memory order equals program order.
  - On a ready head, register `address` = base_V + imm (mod 2^32, no overflow flag; the memory stage flags out-of-range addresses).
  - Register `ROBEN` = entry ROBEN and `data` = data_V for a store, 0 for a load.
  - Pulse `Read_en` for a load or `Write_en` for a store, then pop the head.
  - Otherwise `Read_en` = `Write_en` = 0, `ROBEN` = 0, and `address`/`data` hold their previous values.
- **Flush.** Highest priority. Clears every busy bit, head, tail and count, and drives both enables and `ROBEN` to 0 at that edge. Any same-cycle alloc or issue is discarded.
- **Count.** count(next) = count + alloc_taken − issue_taken; simultaneous alloc and issue leaves it unchanged.

## Timing
- **Reset values.** `ROBEN`=0, `Read_en`=0, `Write_en`=0, `address`=0, `data`=0, `count`=0, `full`=0; all busy bits 0, head=tail=0. Reset asserted mid-operation behaves identically.
- **Load latency.** A load allocated with ready operands at edge N issues at edge N+1, provided it is at the head. The memory reads at the negedge inside cycle N+1.
- **Operand from CDB.** When a head operand arrives on the CDB at edge N, the entry issues at edge N+1.
- **Store latency.** A store with ready operands whose commit arrives at edge N issues at edge N+1.
- **Enables.** `Read_en` and `Write_en` are never both 1 and each is high for exactly one cycle per access.
- **Throughput.** At most one issue per cycle; back-to-back ready entries issue on consecutive edges.

## Test plan
- **Load issue.** After reset, allocate a load with base_Q=0, base_V=100, imm=4, ROBEN=3 -> next edge: `Read_en`=1, `address`=104, `ROBEN`=3, `data`=0; following edge `Read_en`=0 and `count`=0.
- **Store waits for commit.** Allocate store ROBEN=5 with base_Q=7, data_Q=0, data_V=0xAB. Broadcast CDB tag 7 = 200, then pulse commit 5 two cycles later -> no `Write_en` before commit; `Write_en`=1, `address`=200+imm, `data`=0xAB one edge after commit.
- **In-order blocking and full.** Fill 4 entries: head is an unready load, the rest are ready loads -> `full`=1, no issue. A 5th alloc is dropped. Broadcast the head's tag -> four consecutive `Read_en` pulses in allocation order, ROBENs matching.
- **CDB bypass and wrap-around.** Allocate with alloc_base_Q=9 while the CDB broadcasts 9=0x40 in the same cycle -> the entry issues next edge with address 0x40+imm. Repeat across 10 allocations so the pointers wrap with no lost or duplicated entries.
- **Flush.** With 3 entries, assert `flush` together with `alloc_valid` and a ready head -> no enable pulse, `count`=0, and a later commit for a flushed tag is ignored.
- **Asynchronous reset.** Assert `rst` low mid-cycle while `Write_en`=1 -> outputs go to 0 immediately, without waiting for a clock edge.
